mskaes_word_loader: RTL and testbench

- Upstream input stage of the masked 128-bit AES core.
- Collects an already-shared plaintext and key over a 32-bit-wide word stream (valid/ready), buffers the full 128-bit sharings, then hands them over in one cycle to the core's `valid_in`/`ready` handshake.
- Supports plaintext-only frames that reuse the last loaded key, so multi-block encryption under one key costs 4 beats instead of 8.
- Shares are only ever moved and zeroed, never recombined.

---
 rtl/mskaes_word_loader.sv | 88 ++++++++
 tb/tb_mskaes_word_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mskaes_word_loader.sv
// rtl/mskaes_word_loader.sv - collects a shared 128-bit plaintext/key over a 32-bit word stream
// and hands the full sharings to the masked AES core in one cycle.
module mskaes_word_loader #(
  parameter int d = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_pt_only,
  input  logic [32*d-1:0]   in_word,
  input  logic              clear_key,
  output logic              aes_valid_in,
  input  logic              aes_ready,
  output logic [128*d-1:0]  sh_plaintext,
  output logic [128*d-1:0]  sh_key,
  output logic              key_loaded
);

  typedef enum logic {ST_LOAD, ST_FULL} state_t;

  state_t             r_state;
  logic [2:0]         r_beat;
  logic               r_key_loaded;
  logic               r_pt_only;
  logic [128*d-1:0]   r_pt;
  logic [128*d-1:0]   r_key;

  logic w_accept;
  logic w_clear;
  logic w_last;

  assign in_ready = (r_state == ST_LOAD) & ~rst;
  assign w_accept = in_valid & in_ready;
  assign w_clear  = clear_key & (r_state == ST_LOAD) & (r_beat == 3'd0);
  assign w_last   = r_pt_only ? (r_beat == 3'd3) : (r_beat == 3'd7);

  // Sharings only leave the block while the core is being offered them.
  assign aes_valid_in = (r_state == ST_FULL);
  assign sh_plaintext = (r_state == ST_FULL) ? r_pt  : '0;
  assign sh_key       = (r_state == ST_FULL) ? r_key : '0;
  assign key_loaded   = r_key_loaded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_beat       <= 3'd0;
      r_key_loaded <= 1'b0;
      r_pt_only    <= 1'b0;
      r_pt         <= '0;
      r_key        <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_clear) begin
            r_key        <= '0;
            r_key_loaded <= 1'b0;
          end
          if (w_accept) begin
            // A clear in the same cycle wins, so this frame must carry a key.
            if (r_beat == 3'd0)
              r_pt_only <= in_pt_only & r_key_loaded & ~w_clear;
            if (!r_beat[2])
              r_pt[r_beat[1:0]*(32*d) +: 32*d] <= in_word;
            else
              r_key[r_beat[1:0]*(32*d) +: 32*d] <= in_word;
            if (w_last) begin
              r_beat  <= 3'd0;
              r_state <= ST_FULL;
              if (!r_pt_only)
                r_key_loaded <= 1'b1;
            end else begin
              r_beat <= r_beat + 3'd1;
            end
          end
        end
        ST_FULL: begin
          if (aes_ready) begin
            r_state <= ST_LOAD;
            r_pt    <= '0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mskaes_word_loader.sv
// tb/tb_mskaes_word_loader.sv - directed self-checking bench for mskaes_word_loader.
module tb_mskaes_word_loader;

  localparam int D = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_pt_only;
  logic [32*D-1:0]   in_word;
  logic              clear_key;
  logic              aes_valid_in;
  logic              aes_ready;
  logic [128*D-1:0]  sh_plaintext;
  logic [128*D-1:0]  sh_key;
  logic              key_loaded;

  int n_total = 0;
  int n_bad   = 0;

  mskaes_word_loader #(.d(D)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pt_only   (in_pt_only),
    .in_word      (in_word),
    .clear_key    (clear_key),
    .aes_valid_in (aes_valid_in),
    .aes_ready    (aes_ready),
    .sh_plaintext (sh_plaintext),
    .sh_key       (sh_key),
    .key_loaded   (key_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word k: share0 = k ^ mask, share1 = mask, bit-interleaved (bit i share j at i*2+j).
  function automatic logic [63:0] wd(input int k);
    logic [31:0] m;
    logic [31:0] s0;
    logic [63:0] w;
    m  = 32'hA5A5_A5A5;
    s0 = k[31:0] ^ m;
    for (int i = 0; i < 32; i++) begin
      w[2*i]   = s0[i];
      w[2*i+1] = m[i];
    end
    return w;
  endfunction

  function automatic logic [255:0] blk(input int b);
    return {wd(b+3), wd(b+2), wd(b+1), wd(b)};
  endfunction

  task automatic send(input int base, input int n, input logic pto);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      if (b > 0) chk("no_early_valid", {255'd0, aes_valid_in}, 256'd0);
      in_valid   = 1'b1;
      in_word    = wd(base + b);
      in_pt_only = (b == 0) ? pto : 1'b0;
    end
    @(negedge clk);
    in_valid   = 1'b0;
    in_pt_only = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pt_only = 1'b0; in_word = '0;
    clear_key = 1'b0; aes_ready = 1'b1;
    #1;
    chk("rst_in_ready",   {255'd0, in_ready},     256'd0);
    chk("rst_valid",      {255'd0, aes_valid_in}, 256'd0);
    chk("rst_key_loaded", {255'd0, key_loaded},   256'd0);
    chk("rst_pt",         sh_plaintext,           256'd0);
    chk("rst_key",        sh_key,                 256'd0);
    @(negedge clk); rst = 1'b0;
    #1 chk("post_rst_ready", {255'd0, in_ready}, 256'd1);

    // Full 8-beat frame, core ready immediately
    send(0, 8, 1'b0);
    chk("full_valid",      {255'd0, aes_valid_in}, 256'd1);
    chk("full_in_ready",   {255'd0, in_ready},     256'd0);
    chk("full_pt",         sh_plaintext,           blk(0));
    chk("full_key",        sh_key,                 blk(4));
    chk("full_key_loaded", {255'd0, key_loaded},   256'd1);
    @(negedge clk);
    chk("full_after_valid", {255'd0, aes_valid_in}, 256'd0);
    chk("full_after_ready", {255'd0, in_ready},     256'd1);
    chk("full_after_pt",    sh_plaintext,           256'd0);

    // Back-pressure for 5 cycles
    aes_ready = 1'b0;
    send(8, 8, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    {255'd0, aes_valid_in}, 256'd1);
      chk("bp_in_ready", {255'd0, in_ready},     256'd0);
      chk("bp_pt",       sh_plaintext,           blk(8));
      chk("bp_key",      sh_key,                 blk(12));
      if (i < 4) @(negedge clk);
    end
    aes_ready = 1'b1;
    @(negedge clk);
    chk("bp_done_valid", {255'd0, aes_valid_in}, 256'd0);
    chk("bp_done_pt",    sh_plaintext,           256'd0);
    chk("bp_done_key",   sh_key,                 256'd0);
    chk("bp_done_ready", {255'd0, in_ready},     256'd1);

    // Key reuse: 4-beat plaintext-only frame
    send(16, 4, 1'b1);
    chk("reuse_valid", {255'd0, aes_valid_in}, 256'd1);
    chk("reuse_pt",    sh_plaintext,           blk(16));
    chk("reuse_key",   sh_key,                 blk(12));
    @(negedge clk);
    chk("reuse_done", {255'd0, aes_valid_in}, 256'd0);

    // clear_key at beat 0, then a pt_only frame needs 8 beats
    clear_key = 1'b1;
    @(negedge clk); clear_key = 1'b0;
    chk("clr_key_loaded", {255'd0, key_loaded}, 256'd0);
    send(20, 4, 1'b1);
    chk("clr_no_valid4", {255'd0, aes_valid_in}, 256'd0);
    chk("clr_ready4",    {255'd0, in_ready},     256'd1);
    chk("clr_kl4",       {255'd0, key_loaded},   256'd0);
    send(24, 4, 1'b0);
    chk("clr_valid8", {255'd0, aes_valid_in}, 256'd1);
    chk("clr_pt",     sh_plaintext,           blk(20));
    chk("clr_key",    sh_key,                 blk(24));
    chk("clr_kl8",    {255'd0, key_loaded},   256'd1);
    @(negedge clk);

    // clear_key at beat 2 is ignored
    send(28, 2, 1'b1);
    clear_key = 1'b1;
    @(negedge clk); clear_key = 1'b0;
    chk("midclr_kl", {255'd0, key_loaded}, 256'd1);
    send(30, 2, 1'b0);
    chk("midclr_valid", {255'd0, aes_valid_in}, 256'd1);
    chk("midclr_pt",    sh_plaintext,           blk(28));
    chk("midclr_key",   sh_key,                 blk(24));
    @(negedge clk);

    // pt_only without a key after reset
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    aes_ready = 1'b0;
    send(40, 4, 1'b1);
    chk("nokey_no_valid4", {255'd0, aes_valid_in}, 256'd0);
    chk("nokey_kl4",       {255'd0, key_loaded},   256'd0);
    send(44, 4, 1'b0);
    chk("nokey_valid8", {255'd0, aes_valid_in}, 256'd1);
    chk("nokey_pt",     sh_plaintext,           blk(40));
    chk("nokey_key",    sh_key,                 blk(44));

    // Reset while FULL: outputs drop without a clock edge
    rst = 1'b1;
    #1;
    chk("rfull_valid", {255'd0, aes_valid_in}, 256'd0);
    chk("rfull_kl",    {255'd0, key_loaded},   256'd0);
    chk("rfull_pt",    sh_plaintext,           256'd0);
    chk("rfull_key",   sh_key,                 256'd0);
    chk("rfull_ready", {255'd0, in_ready},     256'd0);
    @(negedge clk); rst = 1'b0;
    send(50, 4, 1'b1);
    chk("rfull_next_no_valid", {255'd0, aes_valid_in}, 256'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
